switch_debounce4: RTL and testbench
===================================

# switch_debounce4

Four-channel input conditioner for the lab board's slide switches/push buttons. It synchronizes four raw asynchronous inputs into the clock domain, debounces each one independently, and presents clean registered levels plus one-cycle edge pulses. Its `sw_q[3:0]` output drives the `a`, `b`, `c` and `d` operands of the downstream four-input AND chain stage (bit 0 to `a`, bit 3 to `d`).

## Interface
- `STABLE_CYCLES`, default 16: number of consecutive cycles the synchronized input must differ from the current output before the output flips. Legal range is 2 to 2^`CNT_W`−1.
- `CNT_W`, default 5: width of each per-channel counter.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears all state immediately.
- `sw_in`  input  4  raw switch levels, asynchronous, may bounce.
- `sw_q`  output  4  debounced registered levels.
- `sw_rise`  output  4  one-cycle pulse per channel on a 0→1 change of `sw_q`.
- `sw_fall`  output  4  one-cycle pulse per channel on a 1→0 change of `sw_q`.
- `busy`  output  1  high while any channel counter is non-zero.

## Operation
- Synchronizer: each channel uses two flops, `s1 <= sw_in`, then `s2 <= s1`. Both reset to 0. Only `s2` is used downstream.
- Each channel has a `CNT_W`-bit counter `cnt` and output flop `q`, both reset to 0.
- Per channel, evaluated on each edge:
  - If `s2 == q`: `cnt <= 0`. No output change.
  - If `s2 != q` and `cnt != STABLE_CYCLES-1`: `cnt <= cnt+1`.
  - If `s2 != q` and `cnt == STABLE_CYCLES-1`: `q <= s2` and `cnt <= 0`. On the same edge, assert `sw_rise` (if `s2`=1) or `sw_fall` (if `s2`=0) for exactly one cycle.
- The counter never wraps. Reaching the terminal count always flips `q` and clears `cnt`.
- Glitch rejection: any return of `s2` to `q` before the terminal count clears `cnt` to 0. A subsequent change restarts counting from 0.
- `sw_rise` and `sw_fall` are registered. They are 0 in every cycle in which that channel's `q` does not change. The two are never high simultaneously on the same bit.
- Channels are fully independent. Simultaneous changes on several channels each complete on their own schedule, and several pulse bits may be high in the same cycle.
- `busy` = OR over channels of (`cnt != 0`). It is combinational from registers.

## Timing
- Reset values: `sw_q`=0, `sw_rise`=0, `sw_fall`=0, `busy`=0, all `s1`/`s2`/`cnt`=0.
- Reset mid-operation:
  - All counts are discarded and `sw_q` returns to 0 asynchronously.
  - After `rst` deasserts, a held-high input is re-debounced from scratch and produces a fresh `sw_rise`.
- Latency: `sw_in` stable-changed before edge k. The edges are:
  - k: `s1` captures the new level.
  - k+1: `s2` captures the new level.
  - k+2 … k+STABLE_CYCLES+1: counting.
  - k+STABLE_CYCLES+1: `sw_q` and the pulse update.
- Net latency is STABLE_CYCLES+2 rising edges, counting edge k as the first. That is 18 edges at the default.
- The pulse is high for the single cycle following the edge on which `sw_q` changes, aligned with the new `sw_q` value.
- Minimum spacing between two changes of one channel's `sw_q` is STABLE_CYCLES cycles.

## Test plan
All scenarios use `STABLE_CYCLES`=4.

- Clean rise: `sw_in`=0000, then `sw_in[0]`→1 and held.
  - `sw_q[0]` = 1 after the 6th rising edge.
  - `sw_rise[0]` high for exactly that one cycle.
  - `busy` high for the 3 preceding cycles.
  - No `sw_fall` activity.
- Glitch reject: `sw_in[1]` pulsed high for 3 cycles, then low.
  - `sw_q[1]` stays 0; `sw_rise[1]` never asserts.
  - `busy` returns to 0 within 2 cycles after `s2` returns low.
- Bounce: `sw_in[2]` toggles 1,0,1,0,1 on consecutive cycles, then held 1.
  - `sw_q[2]` rises exactly once, 6 edges after the final 0→1 transition.
  - Exactly one `sw_rise[2]` pulse.
- Fall and independence: from `sw_q`=1111, `sw_in`→0101 on the same cycle.
  - `sw_q`=0101 after 6 edges.
  - `sw_fall`=1010 for one cycle; `sw_rise`=0000 throughout.
- Reset mid-count: `sw_in[3]`→1, then `rst` pulsed during cycle 3 and `sw_in` held.
  - All outputs 0 immediately on `rst` assertion.
  - `sw_q[3]` rises 6 edges after `rst` deasserts, with a single `sw_rise[3]` pulse.
- Downstream check: drive `sw_q` into the AND chain stage and hold `sw_in`=1111.
  - After debounce, the chain's final output is 1.
  - Dropping `sw_in[3]` to 0 clears it 6 edges later.

Source files
------------

// File: rtl/switch_debounce4.sv
// switch_debounce4: two-flop synchronizer, per-channel debounce counter and
// registered rise/fall pulses for four raw switch inputs.
module switch_debounce4 #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    output logic [3:0] sw_q,
    output logic [3:0] sw_rise,
    output logic [3:0] sw_fall,
    output logic       busy
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);
    logic [3:0] s1_q, s2_q, q_q, q_d, rise_q, rise_d, fall_q, fall_d, flip;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        flip = '0;
        cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            flip[i] = s2_q[i] != q_q[i] && cnt_q[i] == TERM;
            // a return to the current level or a completed flip restarts the count
            cnt_d[i] = (s2_q[i] == q_q[i] || flip[i]) ? '0 : cnt_q[i] + 1'b1;
        end
        q_d = q_q ^ flip;
        rise_d = flip & s2_q;
        fall_d = flip & ~s2_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            q_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q <= '0;
        end else begin
            s1_q <= sw_in;
            s2_q <= s1_q;
            q_q <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q <= cnt_d;
        end
    end
    assign sw_q = q_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
    assign busy = |cnt_q;
endmodule

// File: tb/tb_switch_debounce4.sv
// tb_switch_debounce4: directed scenarios checked against a history-based model
// of the debounce rules plus hand-computed timing expectations.
module tb_switch_debounce4;
    localparam int S = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] sw_in = '0;
    logic [3:0] sw_q, sw_rise, sw_fall;
    logic busy, and_out;
    int checks = 0;
    int errors = 0;

    switch_debounce4 #(.STABLE_CYCLES(S), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .sw_q(sw_q),
        .sw_rise(sw_rise), .sw_fall(sw_fall), .busy(busy)
    );

    always #5 clk = ~clk;
    assign and_out = sw_q[0] & sw_q[1] & sw_q[2] & sw_q[3];

    // Model: the level used at edge m is sw_in sampled two edges earlier; a channel
    // flips once the last S such levels since reset all differ from its output.
    logic [3:0] hist [0:4095];
    int n = 0;
    int base = 1;
    logic [3:0] mq = '0, mr = '0, mf = '0, mb = '0;
    logic all_diff;

    function automatic logic din(int m, int i);
        return (m - 2 >= base) ? hist[m-2][i] : 1'b0;
    endfunction

    always @(posedge rst) begin
        mq = '0; mr = '0; mf = '0; mb = '0;
        base = n + 1;
    end

    always @(posedge clk) begin
        n++;
        hist[n] = sw_in;
        if (rst) begin
            mq = '0; mr = '0; mf = '0; mb = '0;
            base = n + 1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < S; j++)
                    if (n - j < base || din(n - j, i) == mq[i]) all_diff = 1'b0;
                mr[i] = all_diff & ~mq[i];
                mf[i] = all_diff & mq[i];
                if (all_diff) mq[i] = ~mq[i];
                mb[i] = din(n, i) != mq[i];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({sw_q, sw_rise, sw_fall, busy} !== {mq, mr, mf, |mb}) begin
                errors++;
                $display("FAIL model t=%0t q/rise/fall/busy got %b/%b/%b/%b exp %b/%b/%b/%b",
                         $time, sw_q, sw_rise, sw_fall, busy, mq, mr, mf, |mb);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] v);
        @(negedge clk);
        sw_in = v;
    endtask

    task automatic run(input int ne, input int ch, output int first, output int rises,
                       output int falls, output int busys, output logic [3:0] fall_at,
                       output int any_rise);
        logic [3:0] q0;
        q0 = sw_q;
        first = 0; rises = 0; falls = 0; busys = 0; any_rise = 0; fall_at = '0;
        for (int e = 1; e <= ne; e++) begin
            @(posedge clk);
            #1;
            if (first == 0 && sw_q != q0) begin
                first = e;
                fall_at = sw_fall;
            end
            rises += int'(sw_rise[ch]);
            falls += int'(sw_fall[ch]);
            busys += int'(busy);
            any_rise += int'(sw_rise != 4'b0000);
        end
    endtask

    initial begin
        int f, r, fl, b, ar;
        logic [3:0] fa;
        #1;
        chk("reset_q", 16'(sw_q), 16'd0);
        chk("reset_pulses", 16'({sw_rise, sw_fall}), 16'd0);
        chk("reset_busy", 16'(busy), 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_in(4'b0001);
        run(8, 0, f, r, fl, b, fa, ar);
        chk("rise_edge", 16'(f), 16'd6);
        chk("rise_pulses", 16'(r), 16'd1);
        chk("rise_busy_cycles", 16'(b), 16'd3);
        chk("rise_no_fall", 16'(fl), 16'd0);
        chk("rise_q", 16'(sw_q), 16'd1);
        set_in(4'b0011);
        run(3, 1, f, r, fl, b, fa, ar);
        set_in(4'b0001);
        run(8, 1, f, r, fl, b, fa, ar);
        chk("glitch_no_change", 16'(f), 16'd0);
        chk("glitch_no_rise", 16'(r), 16'd0);
        chk("glitch_busy_tail", 16'(b), 16'd2);
        chk("glitch_busy_end", 16'(busy), 16'd0);
        set_in(4'b0101); run(1, 2, f, r, fl, b, fa, ar);
        set_in(4'b0001); run(1, 2, f, r, fl, b, fa, ar);
        set_in(4'b0101); run(1, 2, f, r, fl, b, fa, ar);
        set_in(4'b0001); run(1, 2, f, r, fl, b, fa, ar);
        set_in(4'b0101);
        run(9, 2, f, r, fl, b, fa, ar);
        chk("bounce_edge", 16'(f), 16'd6);
        chk("bounce_pulses", 16'(r), 16'd1);
        chk("bounce_q", 16'(sw_q), 16'd5);
        set_in(4'b1111);
        run(10, 1, f, r, fl, b, fa, ar);
        chk("all_high", 16'(sw_q), 16'd15);
        set_in(4'b0101);
        run(8, 1, f, r, fl, b, fa, ar);
        chk("fall_edge", 16'(f), 16'd6);
        chk("fall_vector", 16'(fa), 16'd10);
        chk("fall_pulses", 16'(fl), 16'd1);
        chk("fall_no_rise", 16'(ar), 16'd0);
        chk("fall_q", 16'(sw_q), 16'd5);
        set_in(4'b1101);
        run(3, 3, f, r, fl, b, fa, ar);
        chk("pre_reset_busy", 16'(busy), 16'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_q", 16'(sw_q), 16'd0);
        chk("rst_pulses", 16'({sw_rise, sw_fall}), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(8, 3, f, r, fl, b, fa, ar);
        chk("rerise_edge", 16'(f), 16'd6);
        chk("rerise_pulses", 16'(r), 16'd1);
        chk("rerise_q", 16'(sw_q), 16'd13);
        set_in(4'b1111);
        run(10, 1, f, r, fl, b, fa, ar);
        chk("and_high", 16'(and_out), 16'd1);
        set_in(4'b0111);
        run(5, 3, f, r, fl, b, fa, ar);
        chk("and_hold", 16'(and_out), 16'd1);
        run(1, 3, f, r, fl, b, fa, ar);
        chk("and_clear", 16'(and_out), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
